// File: rtl/stream_dmux_n_if.sv
`default_nettype none
// ============================================================================
//  Module   : stream_dmux_n_if
//  Purpose  : Input stream and per-channel output bundle for stream_dmux_n.
//  Revision : 1.0 - initial release
// ============================================================================
interface stream_dmux_n_if #(
    parameter int DW  = 8,
    parameter int NCH = 4,
    parameter int SW  = 2
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [SW-1:0]     in_sel;
    logic              in_last;
    logic [NCH-1:0]    out_valid;
    logic [NCH-1:0]    out_ready;
    logic [NCH*DW-1:0] out_data;
    logic [NCH-1:0]    out_last;
    logic              busy;

    // Demux side: consumes the input stream, sources the channel streams.
    modport slave (
        input  in_valid, in_data, in_sel, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );

    // Environment side: packet source plus channel sinks.
    modport master (
        output in_valid, in_data, in_sel, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/stream_dmux_n.sv
`default_nettype none
// ============================================================================
//  Module   : stream_dmux_n
//  Purpose  : Packet-aware 1-to-NCH stream demux with a one-entry register
//             per output channel. Optional macro STREAM_DMUX_DROP_CNT_EN adds
//             a saturating count of discarded beats on drop_cnt.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_dmux_n #(
    parameter int DW  = 8,
    parameter int NCH = 4,
    parameter int SW  = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    stream_dmux_n_if.slave     bus
`ifdef STREAM_DMUX_DROP_CNT_EN
    ,
    output logic [15:0]        drop_cnt
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PKT  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [SW-1:0]     r_cur_ch;

    logic [NCH-1:0]    r_out_valid;
    logic [NCH-1:0]    r_out_last;
    logic [NCH*DW-1:0] r_out_data;

    logic [SW-1:0]     w_tgt;
    logic              w_sel_ok;
    logic              w_discard;
    logic              w_busy;
    logic [NCH-1:0]    w_hit;
    logic              w_room;
    logic              w_in_ready;
    logic              w_acc;
    logic [NCH-1:0]    w_load;

    assign w_sel_ok = (32'(bus.in_sel) < NCH);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_acc && !bus.in_last) begin
                    w_state_nxt = w_sel_ok ? S_PKT : S_DROP;
                end
            end
            S_PKT, S_DROP: begin
                if (w_acc && bus.in_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy    = 1'b1;
        w_tgt     = r_cur_ch;
        w_discard = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy    = 1'b0;
                w_tgt     = bus.in_sel;
                w_discard = !w_sel_ok;
            end
            S_PKT:  w_discard = 1'b0;
            S_DROP: w_discard = 1'b1;
            default: begin
                w_busy    = 1'b0;
                w_discard = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------- routing / ready
    // An out-of-range select yields an all-zero hit vector, so no channel loads.
    always_comb begin
        w_hit = '0;
        for (int c = 0; c < NCH; c++) begin
            w_hit[c] = (w_tgt == SW'(c));
        end
    end

    // A full register that drains this cycle can accept a new beat at once.
    assign w_room     = |(w_hit & (~r_out_valid | bus.out_ready));
    assign w_in_ready = w_discard | w_room;
    assign w_acc      = bus.in_valid & w_in_ready;
    assign w_load     = w_hit & {NCH{w_acc & ~w_discard}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_ch <= '0;
        end else if (r_state == S_IDLE && w_acc && w_sel_ok) begin
            r_cur_ch <= bus.in_sel;
        end
    end

    // ------------------------------------------------------ output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= '0;
            r_out_last  <= '0;
            r_out_data  <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_load[c]) begin
                    r_out_valid[c]          <= 1'b1;
                    r_out_last[c]           <= bus.in_last;
                    r_out_data[c*DW +: DW]  <= bus.in_data;
                end else if (r_out_valid[c] && bus.out_ready[c]) begin
                    r_out_valid[c]          <= 1'b0;
                end
            end
        end
    end

`ifdef STREAM_DMUX_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_acc && w_discard && r_drop_cnt != 16'hFFFF) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_stream_dmux_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_dmux_n
//  Purpose  : Directed self-checking bench for stream_dmux_n (NCH=4 and NCH=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_dmux_n;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    stream_dmux_n_if #(.DW(8), .NCH(4), .SW(2)) a ();
    stream_dmux_n_if #(.DW(8), .NCH(3), .SW(2)) b ();

`ifdef STREAM_DMUX_DROP_CNT_EN
    logic [15:0] w_drop_a;
    logic [15:0] w_drop_b;
`endif

    stream_dmux_n #(.DW(8), .NCH(4), .SW(2)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (a)
`ifdef STREAM_DMUX_DROP_CNT_EN
        ,
        .drop_cnt (w_drop_a)
`endif
    );

    stream_dmux_n #(.DW(8), .NCH(3), .SW(2)) u_dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (b)
`ifdef STREAM_DMUX_DROP_CNT_EN
        ,
        .drop_cnt (w_drop_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic l);
        a.in_valid = v;
        a.in_sel   = sel;
        a.in_data  = d;
        a.in_last  = l;
    endtask

    task automatic drive_b(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic l);
        b.in_valid = v;
        b.in_sel   = sel;
        b.in_data  = d;
        b.in_last  = l;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        drive_b(1'b0, 2'd0, 8'h00, 1'b0);
        a.out_ready = 4'hF;
        b.out_ready = 3'b111;

        // Reset and idle
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        check("rst_out_valid", 32'(a.out_valid), 32'h0);
        check("rst_out_last",  32'(a.out_last),  32'h0);
        check("rst_out_data",  a.out_data,       32'h0);
        check("rst_busy",      32'(a.busy),      32'h0);
        check("rst_in_ready",  32'(a.in_ready),  32'h1);
`ifdef STREAM_DMUX_DROP_CNT_EN
        check("rst_drop_cnt",  32'(w_drop_b),    32'h0);
`endif

        // Single-beat packets to every channel
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 2'(i), 8'hA0 + 8'(i), 1'b1);
            cyc();
            check("sb_out_valid", 32'(a.out_valid), 32'(1 << i));
            check("sb_out_last",  32'(a.out_last & a.out_valid), 32'(1 << i));
            check("sb_out_data",  32'(a.out_data[i*8 +: 8]), 32'hA0 + 32'(i));
            check("sb_busy",      32'(a.busy), 32'h0);
        end
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        cyc();
        check("sb_drained", 32'(a.out_valid), 32'h0);

        // Three-beat packet locked to channel 2
        drive_a(1'b1, 2'd2, 8'h11, 1'b0);
        cyc();
        check("p3_b1_valid", 32'(a.out_valid), 32'h4);
        check("p3_b1_data",  32'(a.out_data[16 +: 8]), 32'h11);
        check("p3_b1_busy",  32'(a.busy), 32'h1);
        drive_a(1'b1, 2'd0, 8'h22, 1'b0);
        cyc();
        check("p3_b2_valid", 32'(a.out_valid), 32'h4);
        check("p3_b2_data",  32'(a.out_data[16 +: 8]), 32'h22);
        check("p3_b2_busy",  32'(a.busy), 32'h1);
        drive_a(1'b1, 2'd0, 8'h33, 1'b1);
        cyc();
        check("p3_b3_valid", 32'(a.out_valid), 32'h4);
        check("p3_b3_data",  32'(a.out_data[16 +: 8]), 32'h33);
        check("p3_b3_last",  32'(a.out_last[2]), 32'h1);
        check("p3_b3_busy",  32'(a.busy), 32'h0);
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        cyc();

        // Channel 1 stalled while a packet to channel 3 completes
        a.out_ready = 4'b1101;
        drive_a(1'b1, 2'd1, 8'h55, 1'b1);
        cyc();
        check("st_ch1_valid", 32'(a.out_valid), 32'h2);
        drive_a(1'b1, 2'd3, 8'h77, 1'b0);
        cyc();
        check("st_ch3_b1_valid", 32'(a.out_valid), 32'hA);
        drive_a(1'b1, 2'd0, 8'h88, 1'b1);
        cyc();
        check("st_ch3_b2_valid", 32'(a.out_valid), 32'hA);
        check("st_ch3_b2_data",  32'(a.out_data[24 +: 8]), 32'h88);
        check("st_ch1_held",     32'(a.out_data[8 +: 8]),  32'h55);
        drive_a(1'b1, 2'd1, 8'h66, 1'b1);
        #1;
        check("st_in_ready_low", 32'(a.in_ready), 32'h0);
        cyc();
        check("st_ch3_drained", 32'(a.out_valid), 32'h2);
        check("st_ch1_still",   32'(a.out_data[8 +: 8]), 32'h55);
        check("st_busy",        32'(a.busy), 32'h0);
        a.out_ready = 4'hF;
        #1;
        check("st_in_ready_rel", 32'(a.in_ready), 32'h1);
        cyc();
        check("st_ch1_new_valid", 32'(a.out_valid), 32'h2);
        check("st_ch1_new_data",  32'(a.out_data[8 +: 8]), 32'h66);
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        cyc();
        check("st_drained", 32'(a.out_valid), 32'h0);

        // Out-of-range select on the 3-channel instance
        drive_b(1'b1, 2'd3, 8'h99, 1'b0);
        #1;
        check("dr_in_ready", 32'(b.in_ready), 32'h1);
        cyc();
        check("dr_b1_valid", 32'(b.out_valid), 32'h0);
        check("dr_b1_busy",  32'(b.busy), 32'h1);
        drive_b(1'b1, 2'd0, 8'hAA, 1'b1);
        #1;
        check("dr_b2_in_ready", 32'(b.in_ready), 32'h1);
        cyc();
        check("dr_b2_valid", 32'(b.out_valid), 32'h0);
        check("dr_b2_busy",  32'(b.busy), 32'h0);
`ifdef STREAM_DMUX_DROP_CNT_EN
        check("dr_drop_cnt", 32'(w_drop_b), 32'h2);
        check("dr_drop_a",   32'(w_drop_a), 32'h0);
`endif
        drive_b(1'b0, 2'd0, 8'h00, 1'b0);

        // Reset in the middle of a packet with channel 0 holding a beat
        a.out_ready = 4'b1110;
        drive_a(1'b1, 2'd0, 8'hC0, 1'b0);
        cyc();
        check("mr_pre_valid", 32'(a.out_valid), 32'h1);
        check("mr_pre_busy",  32'(a.busy), 32'h1);
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mr_valid_clr", 32'(a.out_valid), 32'h0);
        check("mr_busy_clr",  32'(a.busy), 32'h0);
        cyc();
        rst_n = 1'b1;
        a.out_ready = 4'hF;
        drive_a(1'b1, 2'd1, 8'hD1, 1'b1);
        cyc();
        check("mr_post_valid", 32'(a.out_valid), 32'h2);
        check("mr_post_data",  32'(a.out_data[8 +: 8]), 32'hD1);
        check("mr_post_busy",  32'(a.busy), 32'h0);
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_dmux_n.md
Name: stream_dmux_n

Overview:
- Parametrised 1-to-NCH stream demultiplexer, successor to the 4-way combinational dmux.
- Routes a valid/ready input stream to one of NCH output channels.
- Packet-aware: the channel is chosen on the first beat of a packet and locked until the `last` beat.
- Each output channel has a one-entry output register, so channels drain independently.
- Sits between a packet source (e.g. a parser) and per-channel consumers.

Parameters:
- DW, 8, data width in bits.
- NCH, 4, number of output channels (2..16).
- SW, 2, select width; must satisfy 2^SW >= NCH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  DW  input beat data.
- in_sel  in  SW  destination channel; sampled only on the first beat of a packet.
- in_last  in  1  final beat of the packet.
- out_valid  out  NCH  per-channel beat valid.
- out_ready  in  NCH  per-channel sink ready.
- out_data  out  NCH*DW  channel c occupies bits [c*DW +: DW].
- out_last  out  NCH  per-channel last flag.
- busy  out  1  high while a packet is in progress (state != IDLE).

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, cur_ch = 0.
  - All out_valid, out_last and out_data bits = 0.
  - busy = 0.
- Handshakes:
  - Beat transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid[c] & out_ready[c].
- Target channel:
  - In IDLE, tgt = in_sel.
  - In PKT, tgt = cur_ch.
- in_ready:
  - IDLE with in_sel >= NCH, or DROP: in_ready = 1.
  - Otherwise: in_ready = !out_valid[tgt] | out_ready[tgt]. This allows a full register to drain and refill in the same cycle.
  - This is a combinational path from out_ready to in_ready; it is allowed.
- Latency: a beat accepted at edge k is visible on out_*[tgt] after edge k (1 cycle).
- Output register c:
  - Loads in_data/in_last on an accepted beat with tgt == c; out_valid[c] = 1.
  - Clears out_valid[c] on an output transfer with no simultaneous load.
  - Holds data and last while stalled (out_valid[c] & !out_ready[c]).
  - Registers of other channels continue draining independently.
- FSM states: IDLE, PKT, DROP.
  - IDLE, accepted beat, in_sel < NCH: cur_ch <= in_sel; beat routed. Go to PKT if !in_last, stay IDLE if in_last (single-beat packet).
  - IDLE, accepted beat, in_sel >= NCH: beat discarded, no output change. Go to DROP if !in_last, else stay IDLE.
  - PKT: in_sel ignored; beats go to cur_ch. An accepted beat with in_last returns to IDLE.
  - DROP: all beats discarded. An accepted beat with in_last returns to IDLE.
- Back-to-back packets: a new packet's first beat may be accepted in the cycle right after the previous last beat, including to a different channel.
- in_valid low: no state change. X on in_data is tolerated when in_valid = 0.
- Mid-packet reset: the FSM returns to IDLE and all pending output beats are lost. After release, the next accepted beat is treated as a packet start.

Optional Feature:
- Macro: STREAM_DMUX_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt [15:0], reset to 0.
  - Increments by 1 per discarded beat (IDLE with invalid sel, or DROP).
  - Saturates at 16'hFFFF.
- Undefined: the port and counter are absent; discard behaviour is otherwise identical.

Test Plan:
- Reset, then hold in_valid = 0 -> out_valid = 4'b0000, busy = 0, in_ready = 1.
- Single-beat packets, in_sel = 0..3, data 8'hA0..A3, all out_ready = 1 -> each appears one cycle later only on its channel with out_last = 1; busy stays 0.
- 3-beat packet: sel = 2 on beat 1, sel = 0 on beats 2–3, data 11/22/33 -> all three beats on channel 2; busy high from after beat 1 until after beat 3.
- Channel 1 stalled (out_ready[1] = 0) with one beat held, second beat to channel 1 -> in_ready = 0 and data held. Meanwhile a packet to channel 3 completes. Release out_ready[1] -> second beat accepted the same cycle.
- NCH = 3, in_sel = 3, 2-beat packet -> both beats accepted and discarded, no out_valid. With STREAM_DMUX_DROP_CNT_EN, drop_cnt = 2.
- Assert rst_n = 0 mid-packet with channel 0 holding a beat -> out_valid cleared and state IDLE. After release, a beat with sel = 1 routes to channel 1.
